// File: rtl/dma_axi_arb_if.sv
// Bundle of the burst command, write/read beat, DMA handshake and memory mux signals
// exchanged between the AXI front-end, the arbiter and the DMA/AXI memory mux.
interface dma_axi_arb_if #(
  parameter int ADDRWIDTH = 11,
  parameter int NUMLANES  = 8,
  parameter int WIDTH     = 16,
  parameter int LENW      = 8
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [ADDRWIDTH-1:0]        cmd_addr;
  logic [LENW-1:0]             cmd_len;
  logic                        wvalid;
  logic                        wready;
  logic [NUMLANES*WIDTH-1:0]   wdata;
  logic                        rvalid;
  logic [NUMLANES*WIDTH-1:0]   rdata;
  logic                        rlast;
  logic                        dma_pending;
  logic                        dma_stall;
  logic                        axi_req_en;
  logic                        axi_req_type;
  logic [ADDRWIDTH-1:0]        axi_addr;
  logic [NUMLANES*WIDTH-1:0]   axi_data;
  logic [NUMLANES*WIDTH-1:0]   mem_readdata;
  logic                        busy;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wvalid, wdata, dma_pending, mem_readdata,
    output cmd_ready, wready, rvalid, rdata, rlast, dma_stall, axi_req_en, axi_req_type,
           axi_addr, axi_data, busy
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wvalid, wdata, dma_pending, mem_readdata,
    input  cmd_ready, wready, rvalid, rdata, rlast, dma_stall, axi_req_en, axi_req_type,
           axi_addr, axi_data, busy
  );
endinterface

// File: rtl/dma_axi_arb.sv
// AXI burst sequencer for the lane-banked vector memory: issues one beat per cycle, stalls DMA
// on AXI beats and yields one slot after MAXRUN contended beats. Optional: DMA_AXI_ARB_STATS_EN.
module dma_axi_arb #(
  parameter int ADDRWIDTH = 11,
  parameter int NUMLANES  = 8,
  parameter int WIDTH     = 16,
  parameter int LENW      = 8,
  parameter int MAXRUN    = 4,
  parameter int RDLAT     = 1
) (
  input  logic         clk,
  input  logic         resetn,
  dma_axi_arb_if.slave bus
`ifdef DMA_AXI_ARB_STATS_EN
  ,
  output logic [15:0]  stat_beats,
  output logic [15:0]  stat_yields
`endif
);
  // state | meaning
  // IDLE  | waiting for a burst command, cmd_ready=1
  // RUN   | issuing beats; write beats gated by wvalid
  // YIELD | single cycle handed to DMA after MAXRUN contended beats

  localparam int DW   = NUMLANES * WIDTH;
  localparam int RUNW = (MAXRUN > 1) ? $clog2(MAXRUN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, YIELD} state_t;

  state_t               state_q, state_d;
  logic                 write_q;
  logic [ADDRWIDTH-1:0] base_q;
  logic [LENW-1:0]      len_q;
  logic [LENW:0]        beat_q;
  logic [RUNW-1:0]      run_q;
  logic [RDLAT-1:0]     rd_vld_q;
  logic [RDLAT-1:0]     rd_last_q;

  logic        accept, fire, last_beat, yield_now;
  logic [31:0] beat_off;

  assign accept    = (state_q == IDLE) && bus.cmd_valid;
  assign fire      = (state_q == RUN) && (!write_q || bus.wvalid);
  assign last_beat = (beat_q == {1'b0, len_q});
  // The last beat never yields: the burst ends there and DMA gets the memory anyway.
  assign yield_now = fire && !last_beat && bus.dma_pending && (run_q == RUNW'(MAXRUN - 1));
  assign beat_off  = 32'(beat_q) * NUMLANES;

  always_comb begin
    state_d          = state_q;
    bus.cmd_ready    = 1'b0;
    bus.wready       = 1'b0;
    bus.axi_req_en   = 1'b0;
    bus.axi_req_type = 1'b0;
    bus.axi_addr     = '0;
    bus.dma_stall    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = RUN;
      end
      RUN: begin
        bus.wready       = write_q;
        bus.axi_req_en   = fire;
        bus.axi_req_type = write_q;
        bus.axi_addr     = base_q + beat_off[ADDRWIDTH-1:0];
        bus.dma_stall    = fire;
        if (fire && last_beat) state_d = IDLE;
        else if (yield_now)    state_d = YIELD;
      end
      YIELD: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign bus.axi_data = bus.wdata;
  assign bus.rvalid   = rd_vld_q[RDLAT-1];
  assign bus.rlast    = rd_vld_q[RDLAT-1] & rd_last_q[RDLAT-1];
  assign bus.rdata    = rd_vld_q[RDLAT-1] ? bus.mem_readdata : {DW{1'b0}};
  assign bus.busy     = (state_q != IDLE) || (|rd_vld_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      run_q     <= '0;
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus.cmd_write;
        base_q  <= bus.cmd_addr;
        len_q   <= bus.cmd_len;
        beat_q  <= '0;
        run_q   <= '0;
      end else if (fire) begin
        beat_q <= beat_q + 1'b1;
        if (!bus.dma_pending || yield_now) run_q <= '0;
        else                               run_q <= run_q + 1'b1;
      end else if (!bus.dma_pending) begin
        run_q <= '0;
      end
      rd_vld_q[0]  <= fire && !write_q;
      rd_last_q[0] <= fire && !write_q && last_beat;
      for (int i = 1; i < RDLAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

`ifdef DMA_AXI_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_beats  <= '0;
      stat_yields <= '0;
    end else begin
      if (fire && stat_beats != 16'hFFFF)       stat_beats  <= stat_beats + 1'b1;
      if (yield_now && stat_yields != 16'hFFFF) stat_yields <= stat_yields + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_axi_arb.sv
// Directed bench for dma_axi_arb: read/write bursts, fairness yields, address wrap,
// async reset mid-burst and back-to-back bursts with reads in flight.
module tb_dma_axi_arb;
  localparam int RDLAT = 2;
  localparam int DW    = 128;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dma_axi_arb_if #(.ADDRWIDTH(11), .NUMLANES(8), .WIDTH(16), .LENW(8)) bif ();

`ifdef DMA_AXI_ARB_STATS_EN
  logic [15:0] stat_beats, stat_yields;
  dma_axi_arb #(.RDLAT(RDLAT)) dut (.clk(clk), .resetn(resetn), .bus(bif),
                                    .stat_beats(stat_beats), .stat_yields(stat_yields));
`else
  dma_axi_arb #(.RDLAT(RDLAT)) dut (.clk(clk), .resetn(resetn), .bus(bif));
`endif

  task automatic start_cmd(input logic wr, input logic [10:0] addr, input logic [7:0] len);
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = addr;
    bif.cmd_len   = len;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bif.cmd_valid = 0; bif.cmd_write = 0; bif.cmd_addr = '0; bif.cmd_len = '0;
    bif.wvalid = 0; bif.wdata = '0; bif.dma_pending = 0; bif.mem_readdata = '0;
    resetn = 1'b0;
    #1;
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", bif.cmd_ready); end
    checks++; if (bif.axi_req_en !== 1'b0) begin errors++; $display("FAIL reset_req_en got %b exp 0", bif.axi_req_en); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bif.busy); end
    checks++; if (bif.rvalid !== 1'b0 || bif.wready !== 1'b0 || bif.dma_stall !== 1'b0)
      begin errors++; $display("FAIL reset_outs got rv=%b wr=%b st=%b exp 0", bif.rvalid, bif.wready, bif.dma_stall); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_read_burst();
    logic exp_en, exp_rv;
    start_cmd(1'b0, 11'h010, 8'd3);
    for (int c = 0; c < 4 + RDLAT + 2; c++) begin
      bif.mem_readdata = {4{32'hA5000000 + 32'(c)}};
      #1;
      exp_en = (c < 4);
      exp_rv = (c >= RDLAT) && (c < 4 + RDLAT);
      checks++; if (bif.axi_req_en !== exp_en) begin errors++; $display("FAIL rd_req_en c=%0d got %b exp %b", c, bif.axi_req_en, exp_en); end
      checks++; if (bif.dma_stall !== exp_en) begin errors++; $display("FAIL rd_dma_stall c=%0d got %b exp %b", c, bif.dma_stall, exp_en); end
      if (exp_en) begin
        checks++; if (bif.axi_addr !== 11'(11'h010 + 8 * c) || bif.axi_req_type !== 1'b0)
          begin errors++; $display("FAIL rd_addr c=%0d got %h/%b exp %h/0", c, bif.axi_addr, bif.axi_req_type, 11'(11'h010 + 8 * c)); end
      end
      checks++; if (bif.rvalid !== exp_rv) begin errors++; $display("FAIL rd_rvalid c=%0d got %b exp %b", c, bif.rvalid, exp_rv); end
      checks++; if (bif.rlast !== (c == 3 + RDLAT)) begin errors++; $display("FAIL rd_rlast c=%0d got %b exp %b", c, bif.rlast, (c == 3 + RDLAT)); end
      if (exp_rv) begin
        checks++; if (bif.rdata !== {4{32'hA5000000 + 32'(c)}}) begin errors++; $display("FAIL rd_rdata c=%0d got %h", c, bif.rdata); end
      end
      checks++; if (bif.busy !== (c < 4 + RDLAT)) begin errors++; $display("FAIL rd_busy c=%0d got %b exp %b", c, bif.busy, (c < 4 + RDLAT)); end
      checks++; if (bif.cmd_ready !== (c >= 4)) begin errors++; $display("FAIL rd_cmd_ready c=%0d got %b exp %b", c, bif.cmd_ready, (c >= 4)); end
      @(negedge clk);
    end
  endtask

  task automatic test_write_gaps();
    logic [3:0] pat;
    int beat;
    pat  = 4'b1101;
    beat = 0;
    start_cmd(1'b1, 11'h100, 8'd2);
    for (int c = 0; c < 6; c++) begin
      bif.wvalid = (c < 4) ? pat[c] : 1'b0;
      bif.wdata  = {8{16'(16'h1111 * (c + 1))}};
      #1;
      checks++; if (bif.axi_req_en !== bif.wvalid) begin errors++; $display("FAIL wr_req_en c=%0d got %b exp %b", c, bif.axi_req_en, bif.wvalid); end
      checks++; if (bif.wready !== (c < 4)) begin errors++; $display("FAIL wr_wready c=%0d got %b exp %b", c, bif.wready, (c < 4)); end
      if (bif.wvalid) begin
        checks++; if (bif.axi_req_type !== 1'b1 || bif.axi_addr !== 11'(11'h100 + 8 * beat))
          begin errors++; $display("FAIL wr_beat c=%0d got %b/%h exp 1/%h", c, bif.axi_req_type, bif.axi_addr, 11'(11'h100 + 8 * beat)); end
        checks++; if (bif.axi_data !== {8{16'(16'h1111 * (c + 1))}}) begin errors++; $display("FAIL wr_data c=%0d got %h", c, bif.axi_data); end
        beat++;
      end
      checks++; if (bif.rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid c=%0d got %b exp 0", c, bif.rvalid); end
      @(negedge clk);
    end
    bif.wvalid = 1'b0;
    checks++; if (beat != 3) begin errors++; $display("FAIL wr_beat_count got %0d exp 3", beat); end
  endtask

  task automatic test_fairness();
    logic [12:0] en_pat;
    int beat;
    en_pat = 13'b0110111101111;
    beat   = 0;
    start_cmd(1'b0, 11'h000, 8'd9);
    bif.dma_pending = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #1;
      checks++; if (bif.axi_req_en !== en_pat[c]) begin errors++; $display("FAIL fair_req_en c=%0d got %b exp %b", c, bif.axi_req_en, en_pat[c]); end
      checks++; if (bif.dma_stall !== en_pat[c]) begin errors++; $display("FAIL fair_stall c=%0d got %b exp %b", c, bif.dma_stall, en_pat[c]); end
      checks++; if (bif.cmd_ready !== (c == 12)) begin errors++; $display("FAIL fair_cmd_ready c=%0d got %b exp %b", c, bif.cmd_ready, (c == 12)); end
      if (en_pat[c]) begin
        checks++; if (bif.axi_addr !== 11'(8 * beat)) begin errors++; $display("FAIL fair_addr c=%0d got %h exp %h", c, bif.axi_addr, 11'(8 * beat)); end
        beat++;
      end
      @(negedge clk);
    end
    bif.dma_pending = 1'b0;
    for (int c = 0; c < RDLAT + 1; c++) @(negedge clk);
    #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL fair_busy_end got %b exp 0", bif.busy); end
  endtask

  task automatic test_addr_wrap();
    start_cmd(1'b0, 11'h7FC, 8'd1);
    #1;
    checks++; if (bif.axi_req_en !== 1'b1 || bif.axi_addr !== 11'h7FC) begin errors++; $display("FAIL wrap_beat0 got %b/%h exp 1/7fc", bif.axi_req_en, bif.axi_addr); end
    @(negedge clk); #1;
    checks++; if (bif.axi_req_en !== 1'b1 || bif.axi_addr !== 11'h004) begin errors++; $display("FAIL wrap_beat1 got %b/%h exp 1/004", bif.axi_req_en, bif.axi_addr); end
    @(negedge clk); #1;
    checks++; if (bif.axi_req_en !== 1'b0) begin errors++; $display("FAIL wrap_done got %b exp 0", bif.axi_req_en); end
    for (int c = 0; c < RDLAT + 1; c++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    start_cmd(1'b0, 11'h200, 8'd7);
    for (int c = 0; c < 3; c++) begin
      bif.mem_readdata = {4{32'hBEEF0000 + 32'(c)}};
      #1;
      checks++; if (bif.axi_req_en !== 1'b1 || bif.axi_addr !== 11'(11'h200 + 8 * c))
        begin errors++; $display("FAIL rst_pre_beat c=%0d got %b/%h exp 1/%h", c, bif.axi_req_en, bif.axi_addr, 11'(11'h200 + 8 * c)); end
      if (c < 2) @(negedge clk);
    end
    #1 resetn = 1'b0;
    #1;
    checks++; if (bif.axi_req_en !== 1'b0 || bif.rvalid !== 1'b0 || bif.busy !== 1'b0 || bif.cmd_ready !== 1'b1)
      begin errors++; $display("FAIL rst_async got en=%b rv=%b busy=%b rdy=%b exp 0 0 0 1", bif.axi_req_en, bif.rvalid, bif.busy, bif.cmd_ready); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < RDLAT + 2; c++) begin
      #1;
      checks++; if (bif.rvalid !== 1'b0 || bif.axi_req_en !== 1'b0)
        begin errors++; $display("FAIL rst_after c=%0d got rv=%b en=%b exp 0 0", c, bif.rvalid, bif.axi_req_en); end
      @(negedge clk);
    end
    start_cmd(1'b0, 11'h055, 8'd0);
    for (int c = 0; c < RDLAT + 2; c++) begin
      #1;
      checks++; if (bif.axi_req_en !== (c == 0)) begin errors++; $display("FAIL rst_single_en c=%0d got %b exp %b", c, bif.axi_req_en, (c == 0)); end
      if (c == 0) begin
        checks++; if (bif.axi_addr !== 11'h055) begin errors++; $display("FAIL rst_single_addr got %h exp 055", bif.axi_addr); end
      end
      checks++; if (bif.rvalid !== (c == RDLAT) || bif.rlast !== (c == RDLAT))
        begin errors++; $display("FAIL rst_single_r c=%0d got rv=%b rl=%b exp %b", c, bif.rvalid, bif.rlast, (c == RDLAT)); end
      checks++; if (bif.cmd_ready !== (c >= 1)) begin errors++; $display("FAIL rst_single_rdy c=%0d got %b exp %b", c, bif.cmd_ready, (c >= 1)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] en_pat, rv_pat, rl_pat, cr_pat, by_pat;
    logic [10:0] exp_addr;
    en_pat = 10'b0000111011;
    rv_pat = en_pat << RDLAT;
    rl_pat = 10'b0010001000;
    cr_pat = 10'b1111000100;
    by_pat = 10'b0011111111;
    start_cmd(1'b0, 11'h300, 8'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_addr = 11'h340; bif.cmd_len = 8'd2;
      end else begin
        bif.cmd_valid = 1'b0;
      end
      bif.mem_readdata = {4{32'hC0DE0000 + 32'(c)}};
      #1;
      case (c)
        0: exp_addr = 11'h300;
        1: exp_addr = 11'h308;
        3: exp_addr = 11'h340;
        4: exp_addr = 11'h348;
        default: exp_addr = 11'h350;
      endcase
      checks++; if (bif.axi_req_en !== en_pat[c]) begin errors++; $display("FAIL b2b_en c=%0d got %b exp %b", c, bif.axi_req_en, en_pat[c]); end
      if (en_pat[c]) begin
        checks++; if (bif.axi_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr c=%0d got %h exp %h", c, bif.axi_addr, exp_addr); end
      end
      checks++; if (bif.rvalid !== rv_pat[c]) begin errors++; $display("FAIL b2b_rvalid c=%0d got %b exp %b", c, bif.rvalid, rv_pat[c]); end
      checks++; if (bif.rlast !== rl_pat[c]) begin errors++; $display("FAIL b2b_rlast c=%0d got %b exp %b", c, bif.rlast, rl_pat[c]); end
      if (rv_pat[c]) begin
        checks++; if (bif.rdata !== {4{32'hC0DE0000 + 32'(c)}}) begin errors++; $display("FAIL b2b_rdata c=%0d got %h", c, bif.rdata); end
      end
      checks++; if (bif.cmd_ready !== cr_pat[c]) begin errors++; $display("FAIL b2b_cmd_ready c=%0d got %b exp %b", c, bif.cmd_ready, cr_pat[c]); end
      checks++; if (bif.busy !== by_pat[c]) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, bif.busy, by_pat[c]); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_write_gaps();
    test_fairness();
    test_addr_wrap();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_axi_arb.md
Name: dma_axi_arb

Overview:
Sequences AXI-side burst commands into per-beat accesses of the lane-banked vector local memory. It drives the axi_req_en/axi_req_type/axi_addr/axi_data inputs of the DMA/AXI memory mux and returns read data.
Because the mux gives AXI absolute priority, this block stalls the DMA engine during AXI beats and yields bounded slots to it, so DMA is never starved.
Sits between the AXI slave front-end and the memory mux.

Parameters:
ADDRWIDTH, 11, per-lane word address width
NUMLANES, 8, lanes per beat; address stride per beat
WIDTH, 16, bits per lane word
LENW, 8, burst length field width (beats minus 1)
MAXRUN, 4, max consecutive AXI beats while dma_pending before a forced yield; MAXRUN is at least 1
RDLAT, 1, memory read latency in cycles (1..4)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDRWIDTH  base lane address
cmd_len  in  LENW  beats minus 1
wvalid  in  1  write beat data valid
wready  out  1  write beat consumed when wvalid&wready
wdata  in  NUMLANES*WIDTH  write beat data
rvalid  out  1  read beat data valid; no backpressure
rdata  out  NUMLANES*WIDTH  read beat data
rlast  out  1  final beat of the read burst
dma_pending  in  1  OR of DMA rden/wren requests
dma_stall  out  1  DMA must hold its request this cycle
axi_req_en  out  1  to mux: AXI owns memory this cycle
axi_req_type  out  1  to mux: 1=write
axi_addr  out  ADDRWIDTH  to mux: beat address
axi_data  out  NUMLANES*WIDTH  to mux: equals wdata
mem_readdata  in  NUMLANES*WIDTH  from mux/memory
busy  out  1  burst active or reads in flight

Behaviour:
- Reset (resetn low, async): state=IDLE; all counters 0; read-valid pipe cleared; all outputs 0 except cmd_ready=1. In-flight reads are discarded, and a burst interrupted by reset is dropped with no further beats.
- States IDLE, RUN, YIELD.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/write, clear beat counter and run counter, go to RUN. Accept takes one cycle; the first beat can issue the cycle after.
- RUN, beat fire condition: read burst fires every cycle; write burst fires only when wvalid=1.
- RUN outputs: wready = write & RUN; axi_req_en = fire; axi_req_type = latched write; axi_addr = base + beat*NUMLANES, truncated to ADDRWIDTH (wraps modulo 2^ADDRWIDTH).
- dma_stall = axi_req_en (combinational).
- Write stall: if wvalid=0 in RUN, no beat issues, axi_req_en=0 and DMA proceeds. The run counter is not incremented and not cleared.
- Fairness: run counter increments on each fired beat while dma_pending=1 and clears when dma_pending=0. If a beat fires with counter==MAXRUN-1 and more beats remain, go to YIELD and clear the counter.
- YIELD: exactly one cycle; axi_req_en=0, wready=0, cmd_ready=0, dma_stall=0; then return to RUN.
- Last beat (beat==len) fires: go to IDLE. The yield rule does not apply to the last beat.
- cmd_ready=0 in RUN and YIELD. A new command may be accepted while reads of the previous burst are still in flight.
- Read return: each fired read beat enters an RDLAT-deep valid/last shift register. RDLAT cycles after the beat, rvalid=1, rdata=mem_readdata, and rlast=1 for beat==len. Beat order is preserved.
- busy = (state!=IDLE) | any read-pipe stage valid.
- cmd_len=0 yields a single-beat burst. Maximum burst is 2^LENW beats; the beat counter is LENW+1 bits wide.

Optional Feature:
DMA_AXI_ARB_STATS_EN: when defined, adds outputs stat_beats[15:0] and stat_yields[15:0].
- stat_beats counts fired AXI beats; stat_yields counts YIELD entries.
- Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Read burst: addr=0x010, len=3, dma_pending=0 -> axi_addr 0x010,0x018,0x020,0x028 on consecutive cycles; rvalid on 4 cycles starting RDLAT after the first beat; rlast only on the 4th; busy drops afterwards.
- Write burst with wvalid gaps: len=2, wvalid pattern 1,0,1,1 -> exactly 3 beats with axi_req_type=1; axi_req_en=0 in the gap cycle; data order preserved.
- Fairness: MAXRUN=4, read len=9, dma_pending=1 throughout -> beats 4 on, 1 yield, 4 on, 1 yield, 2 on. dma_stall=0 in both yield cycles; there is no yield after the last beat.
- Address wrap: addr=0x7FC, len=1 -> axi_addr 0x7FC then 0x004.
- Async reset mid-burst: assert resetn=0 during beat 2 of a len=7 read -> outputs clear immediately and no rvalid follows. After release, cmd_ready=1 and a new len=0 burst completes with a single beat.
- Back-to-back bursts: with RDLAT=2, accept a second command while the first burst's reads are in flight -> rvalid streams for both bursts with correct rlast placement.
